// File: rtl/multicycle_sequencer_pkg.sv
// Shared types and encodings for the multicycle RV32I control sequencer.
// Holds the FSM state enum, opcode/funct codes, ALU operation codes, and the
// datapath mux select codes driven by the sequencer.
package multicycle_sequencer_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_EXEC_I,
        S_EXEC_R,
        S_ALU_WB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

    localparam logic [2:0] FUN3_BEQ  = 3'b000;
    localparam logic [2:0] FUN3_BNE  = 3'b001;
    localparam logic [2:0] FUN3_ADD  = 3'b000;
    localparam logic [2:0] FUN3_SLL  = 3'b001;
    localparam logic [2:0] FUN3_SLT  = 3'b010;
    localparam logic [2:0] FUN3_SLTU = 3'b011;
    localparam logic [2:0] FUN3_XOR  = 3'b100;
    localparam logic [2:0] FUN3_SR   = 3'b101;
    localparam logic [2:0] FUN3_OR   = 3'b110;
    localparam logic [2:0] FUN3_AND  = 3'b111;

    localparam logic [6:0] FUN7_BASE = 7'b0000000;
    localparam logic [6:0] FUN7_ALT  = 7'b0100000;

    // 4'b0000 is reserved as the "no valid operation" code.
    localparam logic [3:0] ALU_NONE = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_SUB  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_AND  = 4'b1010;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_SRC_I = 2'b00;
    localparam logic [1:0] IMM_SRC_S = 2'b01;
    localparam logic [1:0] IMM_SRC_B = 2'b10;
    localparam logic [1:0] IMM_SRC_J = 2'b11;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RESULT_ALUOUT = 2'b00;
    localparam logic [1:0] RESULT_DATA   = 2'b01;
    localparam logic [1:0] RESULT_ALU    = 2'b10;

    // States that drive mem_req and therefore run the wait counter.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_alu_decoder.sv
// ALU operation decoder.
// Ports: alu_op (sequencer request: ADD/SUB/by-funct), funct3, funct7,
//        op5 (opcode[5], distinguishes R-type from I-ALU), alu_control_c (ALU code).
module multicycle_sequencer_alu_decoder
    import multicycle_sequencer_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       op5,
    output logic [3:0] alu_control_c
);

    // I-type ignores funct7 (it is immediate bits); R-type needs it zero.
    logic r_base;
    assign r_base = !op5 || (funct7 == FUN7_BASE);

    always_comb begin
        alu_control_c = ALU_NONE;
        case (alu_op)
            ALU_OP_ADD: alu_control_c = ALU_ADD;
            ALU_OP_SUB: alu_control_c = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    FUN3_ADD: begin
                        if (op5 && (funct7 == FUN7_ALT)) alu_control_c = ALU_SUB;
                        else if (r_base)                 alu_control_c = ALU_ADD;
                    end
                    FUN3_SLL:  if (funct7 == FUN7_BASE) alu_control_c = ALU_SLL;
                    FUN3_SLT:  if (r_base) alu_control_c = ALU_SLT;
                    FUN3_SLTU: if (r_base) alu_control_c = ALU_SLTU;
                    FUN3_XOR:  if (r_base) alu_control_c = ALU_XOR;
                    FUN3_SR: begin
                        if (funct7 == FUN7_BASE)     alu_control_c = ALU_SRL;
                        else if (funct7 == FUN7_ALT) alu_control_c = ALU_SRA;
                    end
                    FUN3_OR:   if (r_base) alu_control_c = ALU_OR;
                    FUN3_AND:  if (r_base) alu_control_c = ALU_AND;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Main control FSM for a multicycle RV32I datapath with one shared ALU and one
// unified memory port (req/ready). Steps FETCH -> DECODE -> EXEC/MEM -> WB.
// Ports: clk, rst (sync, active-high); opcode/funct3/funct7 from IR; alu_zero;
//        mem_ready; outputs mem_req/mem_we/adr_src, ir_write, pc_write,
//        reg_write_enable, alu_src_a/b, result_src, imm_src, alu_control,
//        instr_retired pulse, sticky illegal_instr / bus_error trap flags.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write_enable,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control,
    output logic       instr_retired,
    output logic       illegal_instr,
    output logic       bus_error
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    state_t            state, state_next;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_next;
    logic              illegal_q, bus_q;
    logic              set_illegal, set_bus;
    logic              timeout_hit;
    logic [1:0]        alu_op;
    logic [3:0]        alu_control_dec;

    multicycle_sequencer_alu_decoder u_alu_decoder (
        .alu_op        (alu_op),
        .funct3        (funct3),
        .funct7        (funct7),
        .op5           (opcode[5]),
        .alu_control_c (alu_control_dec)
    );

    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Counter runs only while a memory state is stalled; any exit or entry restarts it.
    assign wait_cnt_next = (is_mem_state(state) && (state_next == state))
                           ? wait_cnt + CNT_W'(1) : '0;

    // State, wait counter and sticky trap cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_FETCH;
            wait_cnt  <= '0;
            illegal_q <= 1'b0;
            bus_q     <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_bus)     bus_q     <= 1'b1;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next       = state;
        set_illegal      = 1'b0;
        set_bus          = 1'b0;
        alu_op           = ALU_OP_ADD;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        adr_src          = 1'b0;
        ir_write         = 1'b0;
        pc_write         = 1'b0;
        reg_write_enable = 1'b0;
        alu_src_a        = SRC_A_PC;
        alu_src_b        = SRC_B_RS2;
        result_src       = RESULT_ALUOUT;
        imm_src          = IMM_SRC_I;
        instr_retired    = 1'b0;
        illegal_instr    = illegal_q;
        bus_error        = bus_q;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    result_src = RESULT_ALU;
                    state_next = S_DECODE;
                end else if (timeout_hit) begin
                    set_bus    = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                // ALUOut latches OldPC+imm; JAL needs the J-immediate for its target.
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                imm_src   = (opcode == OPCODE_JAL) ? IMM_SRC_J : IMM_SRC_B;
                case (opcode)
                    OPCODE_LOAD, OPCODE_STORE: state_next = S_MEM_ADDR;
                    OPCODE_OP_IMM:             state_next = S_EXEC_I;
                    OPCODE_OP:                 state_next = S_EXEC_R;
                    OPCODE_BRANCH:             state_next = S_BRANCH;
                    OPCODE_JAL:                state_next = S_JAL;
                    default: begin
                        set_illegal = 1'b1;
                        state_next  = S_TRAP;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                imm_src    = (opcode == OPCODE_STORE) ? IMM_SRC_S : IMM_SRC_I;
                state_next = (opcode == OPCODE_STORE) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (timeout_hit) begin
                    set_bus    = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_MEM_WB: begin
                result_src       = RESULT_DATA;
                reg_write_enable = 1'b1;
                instr_retired    = 1'b1;
                state_next       = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_next    = S_FETCH;
                end else if (timeout_hit) begin
                    set_bus    = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_EXEC_I: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALU_OP_FUNCT;
                state_next = S_ALU_WB;
            end
            S_EXEC_R: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_RS2;
                alu_op     = ALU_OP_FUNCT;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_enable = 1'b1;
                instr_retired    = 1'b1;
                state_next       = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_RS2;
                alu_op    = ALU_OP_SUB;
                if ((funct3 == FUN3_BEQ) || (funct3 == FUN3_BNE)) begin
                    pc_write      = (funct3 == FUN3_BEQ) ? alu_zero : !alu_zero;
                    instr_retired = 1'b1;
                    state_next    = S_FETCH;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_TRAP;
                end
            end
            S_JAL: begin
                // PC takes the target held in ALUOut while the ALU forms the link value.
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                pc_write   = 1'b1;
                state_next = S_ALU_WB;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase

        // While reset is asserted every output reads as its reset value.
        alu_control = alu_control_dec;
        if (rst) begin
            mem_req          = 1'b0;
            mem_we           = 1'b0;
            adr_src          = 1'b0;
            ir_write         = 1'b0;
            pc_write         = 1'b0;
            reg_write_enable = 1'b0;
            alu_src_a        = 2'b00;
            alu_src_b        = 2'b00;
            result_src       = 2'b00;
            imm_src          = 2'b00;
            alu_control      = 4'b0000;
            instr_retired    = 1'b0;
            illegal_instr    = 1'b0;
            bus_error        = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer (MEM_TIMEOUT = 4).
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_zero;
    logic       mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write_enable;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [3:0] alu_control;
    logic       instr_retired, illegal_instr, bus_error;

    int n_vec = 0;
    int n_err = 0;

    multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .opcode           (opcode),
        .funct3           (funct3),
        .funct7           (funct7),
        .alu_zero         (alu_zero),
        .mem_ready        (mem_ready),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .adr_src          (adr_src),
        .ir_write         (ir_write),
        .pc_write         (pc_write),
        .reg_write_enable (reg_write_enable),
        .alu_src_a        (alu_src_a),
        .alu_src_b        (alu_src_b),
        .result_src       (result_src),
        .imm_src          (imm_src),
        .alu_control      (alu_control),
        .instr_retired    (instr_retired),
        .illegal_instr    (illegal_instr),
        .bus_error        (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0; alu_zero = 1'b0; mem_ready = 1'b0;
        cyc(); cyc();
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_alu_control", 32'(alu_control), 32'(0));
        chk("rst_alu_src_b", 32'(alu_src_b), 32'(0));
        chk("rst_state", 32'(dut.state), 32'(S_FETCH));
        rst = 1'b0; #1;
        chk("fetch_mem_req", 32'(mem_req), 32'(1));
        chk("fetch_adr_src", 32'(adr_src), 32'(0));

        // addi x1,x0,5
        opcode = OPCODE_OP_IMM; funct3 = 3'b000; funct7 = 7'h00; mem_ready = 1'b1; #1;
        chk("addi_c1_ir_write", 32'(ir_write), 32'(1));
        chk("addi_c1_pc_write", 32'(pc_write), 32'(1));
        chk("addi_c1_result_src", 32'(result_src), 32'(RESULT_ALU));
        chk("addi_c1_src_b", 32'(alu_src_b), 32'(SRC_B_FOUR));
        chk("addi_c1_alu", 32'(alu_control), 32'(ALU_ADD));
        chk("addi_c1_rwe", 32'(reg_write_enable), 32'(0));
        cyc();
        chk("addi_c2_state", 32'(dut.state), 32'(S_DECODE));
        chk("addi_c2_src_a", 32'(alu_src_a), 32'(SRC_A_OLDPC));
        chk("addi_c2_imm_src", 32'(imm_src), 32'(IMM_SRC_B));
        chk("addi_c2_mem_req", 32'(mem_req), 32'(0));
        cyc();
        chk("addi_c3_state", 32'(dut.state), 32'(S_EXEC_I));
        chk("addi_c3_alu", 32'(alu_control), 32'(ALU_ADD));
        chk("addi_c3_rwe", 32'(reg_write_enable), 32'(0));
        chk("addi_c3_retired", 32'(instr_retired), 32'(0));
        cyc();
        chk("addi_c4_state", 32'(dut.state), 32'(S_ALU_WB));
        chk("addi_c4_rwe", 32'(reg_write_enable), 32'(1));
        chk("addi_c4_retired", 32'(instr_retired), 32'(1));
        chk("addi_c4_result_src", 32'(result_src), 32'(RESULT_ALUOUT));
        cyc();
        chk("addi_c5_retired", 32'(instr_retired), 32'(0));
        chk("addi_c5_rwe", 32'(reg_write_enable), 32'(0));
        chk("addi_c5_mem_req", 32'(mem_req), 32'(1));

        // lw with three wait cycles in MEM_READ
        opcode = OPCODE_LOAD; funct3 = 3'b010; #1;
        cyc();
        chk("lw_decode", 32'(dut.state), 32'(S_DECODE));
        mem_ready = 1'b0;
        cyc();
        chk("lw_memaddr_state", 32'(dut.state), 32'(S_MEM_ADDR));
        chk("lw_memaddr_imm", 32'(imm_src), 32'(IMM_SRC_I));
        chk("lw_memaddr_src_a", 32'(alu_src_a), 32'(SRC_A_RS1));
        chk("lw_memaddr_mem_req", 32'(mem_req), 32'(0));
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk("lw_wait_state", 32'(dut.state), 32'(S_MEM_READ));
            chk("lw_wait_mem_req", 32'(mem_req), 32'(1));
            chk("lw_wait_adr_src", 32'(adr_src), 32'(1));
            n_vec++;
            if ((dut.state !== S_MEM_READ) || (mem_req !== 1'b1) || (adr_src !== 1'b1)) begin
                n_err++;
                $error("FAIL lw_wait_inline: state %0h mem_req %0b adr_src %0b", dut.state, mem_req, adr_src);
            end
            cyc();
        end
        mem_ready = 1'b1; #1;
        chk("lw_c7_mem_req", 32'(mem_req), 32'(1));
        chk("lw_c7_adr_src", 32'(adr_src), 32'(1));
        chk("lw_c7_rwe", 32'(reg_write_enable), 32'(0));
        cyc();
        chk("lw_c8_state", 32'(dut.state), 32'(S_MEM_WB));
        chk("lw_c8_result_src", 32'(result_src), 32'(RESULT_DATA));
        chk("lw_c8_rwe", 32'(reg_write_enable), 32'(1));
        chk("lw_c8_retired", 32'(instr_retired), 32'(1));
        cyc();
        chk("lw_back_fetch", 32'(dut.state), 32'(S_FETCH));

        // beq taken
        opcode = OPCODE_BRANCH; funct3 = FUN3_BEQ; alu_zero = 1'b1; #1;
        cyc(); cyc();
        chk("beq_state", 32'(dut.state), 32'(S_BRANCH));
        chk("beq_pc_write", 32'(pc_write), 32'(1));
        chk("beq_retired", 32'(instr_retired), 32'(1));
        chk("beq_alu", 32'(alu_control), 32'(ALU_SUB));
        cyc();
        chk("beq_back_fetch", 32'(dut.state), 32'(S_FETCH));

        // bne with equal operands, then with unequal operands
        funct3 = FUN3_BNE; #1;
        cyc(); cyc();
        chk("bne_z1_pc_write", 32'(pc_write), 32'(0));
        chk("bne_z1_retired", 32'(instr_retired), 32'(1));
        alu_zero = 1'b0; #1;
        chk("bne_z0_pc_write", 32'(pc_write), 32'(1));
        cyc();
        chk("bne_back_fetch", 32'(dut.state), 32'(S_FETCH));

        // sub x3,x1,x2
        opcode = OPCODE_OP; funct3 = 3'b000; funct7 = 7'b0100000; #1;
        cyc(); cyc();
        chk("sub_state", 32'(dut.state), 32'(S_EXEC_R));
        chk("sub_alu", 32'(alu_control), 32'(ALU_SUB));
        chk("sub_src_b", 32'(alu_src_b), 32'(SRC_B_RS2));
        cyc();
        chk("sub_wb_retired", 32'(instr_retired), 32'(1));
        cyc();

        // srai
        opcode = OPCODE_OP_IMM; funct3 = 3'b101; funct7 = 7'b0100000; #1;
        cyc(); cyc();
        chk("srai_alu", 32'(alu_control), 32'(ALU_SRA));
        cyc(); cyc();

        // jal
        opcode = OPCODE_JAL; funct3 = 3'b000; funct7 = 7'h00; #1;
        cyc();
        chk("jal_decode_imm", 32'(imm_src), 32'(IMM_SRC_J));
        cyc();
        chk("jal_state", 32'(dut.state), 32'(S_JAL));
        chk("jal_pc_write", 32'(pc_write), 32'(1));
        chk("jal_src_a", 32'(alu_src_a), 32'(SRC_A_OLDPC));
        chk("jal_src_b", 32'(alu_src_b), 32'(SRC_B_FOUR));
        chk("jal_retired", 32'(instr_retired), 32'(0));
        cyc();
        chk("jal_wb_retired", 32'(instr_retired), 32'(1));
        chk("jal_wb_rwe", 32'(reg_write_enable), 32'(1));
        cyc();

        // sw zero-wait
        opcode = OPCODE_STORE; funct3 = 3'b010; #1;
        cyc(); cyc();
        chk("sw_memaddr_imm", 32'(imm_src), 32'(IMM_SRC_S));
        cyc();
        chk("sw_write_state", 32'(dut.state), 32'(S_MEM_WRITE));
        chk("sw_mem_we", 32'(mem_we), 32'(1));
        chk("sw_retired", 32'(instr_retired), 32'(1));
        cyc();
        chk("sw_back_fetch", 32'(dut.state), 32'(S_FETCH));

        // illegal opcode
        opcode = 7'h7F; #1;
        cyc();
        chk("ill_decode_flag", 32'(illegal_instr), 32'(0));
        cyc();
        chk("ill_state", 32'(dut.state), 32'(S_TRAP));
        chk("ill_flag", 32'(illegal_instr), 32'(1));
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("ill_hold_flag", 32'(illegal_instr), 32'(1));
            chk("ill_hold_mem_req", 32'(mem_req), 32'(0));
            chk("ill_hold_pc_write", 32'(pc_write), 32'(0));
            n_vec++;
            if ((illegal_instr !== 1'b1) || (mem_req !== 1'b0) || (dut.state !== S_TRAP)) begin
                n_err++;
                $error("FAIL ill_hold_inline: flag %0b mem_req %0b state %0h", illegal_instr, mem_req, dut.state);
            end
        end
        rst = 1'b1;
        cyc();
        chk("ill_rst_state", 32'(dut.state), 32'(S_FETCH));
        chk("ill_rst_mem_req", 32'(mem_req), 32'(0));
        mem_ready = 1'b0; rst = 1'b0; opcode = OPCODE_OP_IMM; funct3 = 3'b000; funct7 = 7'h00; #1;
        chk("ill_post_flag", 32'(illegal_instr), 32'(0));

        // fetch timeout with mem_ready stuck low
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_mem_req", 32'(mem_req), 32'(1));
            chk("to_wait_bus_error", 32'(bus_error), 32'(0));
            chk("to_wait_ir_write", 32'(ir_write), 32'(0));
            n_vec++;
            if ((mem_req !== 1'b1) || (bus_error !== 1'b0) || (dut.state !== S_FETCH)) begin
                n_err++;
                $error("FAIL to_wait_inline: mem_req %0b bus_error %0b state %0h", mem_req, bus_error, dut.state);
            end
            cyc();
        end
        chk("to_state", 32'(dut.state), 32'(S_TRAP));
        chk("to_bus_error", 32'(bus_error), 32'(1));
        chk("to_mem_req", 32'(mem_req), 32'(0));
        chk("to_illegal", 32'(illegal_instr), 32'(0));
        rst = 1'b1;
        cyc();
        rst = 1'b0; #1;
        chk("to_post_rst_bus_error", 32'(bus_error), 32'(0));

        // ready on the last allowed cycle wins
        for (int i = 0; i < 3; i++) begin
            chk("to2_wait_mem_req", 32'(mem_req), 32'(1));
            cyc();
        end
        mem_ready = 1'b1; #1;
        chk("to2_ir_write", 32'(ir_write), 32'(1));
        cyc();
        chk("to2_state", 32'(dut.state), 32'(S_DECODE));
        chk("to2_bus_error", 32'(bus_error), 32'(0));
        cyc(); cyc(); cyc();
        chk("to2_back_fetch", 32'(dut.state), 32'(S_FETCH));

        // reset during a stalled store
        opcode = OPCODE_STORE; funct3 = 3'b010; #1;
        cyc();
        mem_ready = 1'b0;
        cyc(); cyc();
        chk("swr_mem_req", 32'(mem_req), 32'(1));
        chk("swr_mem_we", 32'(mem_we), 32'(1));
        chk("swr_adr_src", 32'(adr_src), 32'(1));
        cyc();
        chk("swr_wait_state", 32'(dut.state), 32'(S_MEM_WRITE));
        rst = 1'b1;
        cyc();
        chk("swr_rst_mem_req", 32'(mem_req), 32'(0));
        chk("swr_rst_mem_we", 32'(mem_we), 32'(0));
        chk("swr_rst_adr_src", 32'(adr_src), 32'(0));
        chk("swr_rst_state", 32'(dut.state), 32'(S_FETCH));
        rst = 1'b0; #1;
        chk("swr_post_mem_req", 32'(mem_req), 32'(1));
        chk("swr_post_mem_we", 32'(mem_we), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
